// File: rtl/seg595_pkg.sv
// -----------------------------------------------------------------------------
// seg595_pkg
// Shared definitions for the 74HC595 display bus receiver.
//
// Contents:
//   SEL_W_DEF / SEG_W_DEF  default digit-select and segment field widths
//   SEG_A .. SEG_DP        bit positions of each segment inside the seg field
//   HEX_GLYPH              active-high {g,f,e,d,c,b,a} patterns for 0-F. The
//                          display serializer uses the same table, so the two
//                          ends cannot drift apart.
//   rx_state_e             receiver progress states, used for debug only
// -----------------------------------------------------------------------------
package seg595_pkg;

    localparam int SEL_W_DEF = 6;
    localparam int SEG_W_DEF = 8;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // The leftmost entry of the concatenation is index 15 ('F') and the
    // rightmost is index 0 ('0').
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_LATCHED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/seg595_edge_sync.sv
// -----------------------------------------------------------------------------
// seg595_edge_sync
// Brings one asynchronous bus line into the clock domain through a 2-flop
// synchronizer and produces a registered one-cycle pulse on each rising edge.
//
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset
//   din    in   asynchronous bus line
//   rise   out  one-cycle pulse, 3 clocks after din rises at the pin
// -----------------------------------------------------------------------------
module seg595_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic rise_q, rise_d;

    // Next-state for the synchronizer chain. s3 is the previous value of the
    // synchronized line, so s2 & ~s3 marks the first cycle it reads high.
    // The pulse itself is registered so the edge timing does not depend on
    // how much logic sits downstream.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_d = s2_q & ~s3_q;
    end

    // Registers for the chain and the pulse; reset clears every stage so no
    // phantom edge can appear after reset release.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/seg_595_receiver.sv
// -----------------------------------------------------------------------------
// seg_595_receiver
// Serial-in/parallel-out receiver for the 74HC595 display bus. Samples the
// bus in the sys_clk domain, rebuilds each latched frame {sel, seg}, and
// flags frames with the wrong bit count or a non-one-hot digit select.
//
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   ds, shcp, stcp    serial data, shift clock, storage clock (asynchronous)
//   oe                output enable, active-low (asynchronous)
//   frame_data        last latched frame {sel, seg}
//   sel, seg          the two fields of frame_data
//   digit_idx         position of the set bit in sel, 0 when sel is not one-hot
//   frame_valid       one-cycle pulse per latched frame
//   frame_err         latched frame did not have exactly FRAME_W shifts
//   sel_err           latched sel is not exactly one-hot
//   disp_on           registered ~oe
//   digit_val/_ok     hex digit decoded from seg (decoder build only)
//
// Build option: define SEG595_RX_DECODE_EN to include the glyph decoder.
// Without it digit_val and digit_ok are constant 0.
// -----------------------------------------------------------------------------
module seg_595_receiver
    import seg595_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               ds,
    input  logic               shcp,
    input  logic               stcp,
    input  logic               oe,
    output logic [SEL_W+SEG_W-1:0] frame_data,
    output logic [SEL_W-1:0]   sel,
    output logic [SEG_W-1:0]   seg,
    output logic [2:0]         digit_idx,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               sel_err,
    output logic               disp_on,
    output logic [3:0]         digit_val,
    output logic               digit_ok
);

    localparam int FRAME_W = SEL_W + SEG_W;

    logic               shift_rise;
    logic               latch_rise;

    logic               ds_s1_q, ds_s1_d;
    logic               ds_s2_q, ds_s2_d;
    logic               oe_s1_q, oe_s1_d;
    logic               oe_s2_q, oe_s2_d;

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_data_q, frame_data_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               sel_err_q, sel_err_d;
    logic [2:0]         digit_idx_q, digit_idx_d;
    logic               disp_on_q, disp_on_d;
    rx_state_e          state_q, state_d;

    logic [SEL_W-1:0]   next_sel;
    logic               next_sel_onehot;
    logic [2:0]         next_idx;

    seg595_edge_sync u_shcp_sync (
        .clock (sys_clk),
        .reset (sys_rst),
        .din   (shcp),
        .rise  (shift_rise)
    );

    seg595_edge_sync u_stcp_sync (
        .clock (sys_clk),
        .reset (sys_rst),
        .din   (stcp),
        .rise  (latch_rise)
    );

    // Field checks on the frame that would be latched right now. Only the
    // position of the set bit matters, so a non-one-hot select reports 0.
    always_comb begin
        next_sel        = shreg_q[FRAME_W-1:SEG_W];
        next_sel_onehot = $onehot(next_sel);
        next_idx        = 3'd0;
        for (int i = 0; i < SEL_W; i++) begin
            if (next_sel[i]) begin
                next_idx = 3'(i);
            end
        end
        if (!next_sel_onehot) begin
            next_idx = 3'd0;
        end
    end

    // Main datapath. The latch reads shreg before this cycle's shift, which
    // gives the 595 one-behind behaviour when shcp and stcp rise together;
    // in that case the shift that follows is the first bit of the next frame,
    // so the counter restarts at 1 instead of 0. The counter saturates so
    // that a long burst still reads as "too many bits".
    always_comb begin
        ds_s1_d       = ds;
        ds_s2_d       = ds_s1_q;
        oe_s1_d       = oe;
        oe_s2_d       = oe_s1_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        sel_err_d     = sel_err_q;
        digit_idx_d   = digit_idx_q;
        disp_on_d     = ~oe_s2_q;

        if (latch_rise) begin
            frame_data_d  = shreg_q;
            frame_valid_d = 1'b1;
            frame_err_d   = (bit_cnt_q != 5'(FRAME_W));
            sel_err_d     = ~next_sel_onehot;
            digit_idx_d   = next_idx;
            bit_cnt_d     = 5'd0;
        end

        if (shift_rise) begin
            shreg_d = {shreg_q[FRAME_W-2:0], ds_s2_q};
            if (latch_rise) begin
                bit_cnt_d = 5'd1;
            end else if (bit_cnt_q != 5'd31) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    // Progress tracker for debug. Nothing downstream depends on it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (shift_rise) state_d = ST_SHIFTING;
            ST_SHIFTING: if (latch_rise) state_d = ST_LATCHED;
            ST_LATCHED:  if (shift_rise) state_d = ST_SHIFTING;
            default:     state_d = ST_IDLE;
        endcase
    end

    // All receiver state, including the ds/oe synchronizers. Reset throws
    // away any partially shifted frame along with the held outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ds_s1_q       <= 1'b0;
            ds_s2_q       <= 1'b0;
            oe_s1_q       <= 1'b0;
            oe_s2_q       <= 1'b0;
            shreg_q       <= '0;
            bit_cnt_q     <= 5'd0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            sel_err_q     <= 1'b0;
            digit_idx_q   <= 3'd0;
            disp_on_q     <= 1'b0;
            state_q       <= ST_IDLE;
        end else begin
            ds_s1_q       <= ds_s1_d;
            ds_s2_q       <= ds_s2_d;
            oe_s1_q       <= oe_s1_d;
            oe_s2_q       <= oe_s2_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            sel_err_q     <= sel_err_d;
            digit_idx_q   <= digit_idx_d;
            disp_on_q     <= disp_on_d;
            state_q       <= state_d;
        end
    end

`ifdef SEG595_RX_DECODE_EN
    logic [3:0] digit_val_q, digit_val_d;
    logic       digit_ok_q, digit_ok_d;
    logic [3:0] dec_val;
    logic       dec_ok;

    // Glyph lookup on the segment field about to be latched; dp is ignored.
    // An unknown pattern reports value 0 with ok low.
    always_comb begin
        dec_val = 4'd0;
        dec_ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (shreg_q[SEG_G:SEG_A] == HEX_GLYPH[i]) begin
                dec_val = 4'(i);
                dec_ok  = 1'b1;
            end
        end
    end

    // Decoded digit is captured on the same latch as frame_data.
    always_comb begin
        digit_val_d = digit_val_q;
        digit_ok_d  = digit_ok_q;
        if (latch_rise) begin
            digit_val_d = dec_val;
            digit_ok_d  = dec_ok;
        end
    end

    // Decoder output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            digit_val_q <= 4'd0;
            digit_ok_q  <= 1'b0;
        end else begin
            digit_val_q <= digit_val_d;
            digit_ok_q  <= digit_ok_d;
        end
    end

    assign digit_val = digit_val_q;
    assign digit_ok  = digit_ok_q;
`else
    assign digit_val = 4'd0;
    assign digit_ok  = 1'b0;
`endif

    assign frame_data  = frame_data_q;
    assign sel         = frame_data_q[FRAME_W-1:SEG_W];
    assign seg         = frame_data_q[SEG_W-1:0];
    assign digit_idx   = digit_idx_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign sel_err     = sel_err_q;
    assign disp_on     = disp_on_q;

endmodule

// File: tb/tb_seg_595_receiver.sv
// -----------------------------------------------------------------------------
// tb_seg_595_receiver
// Drives the 595 bus pins slowly relative to sys_clk and compares every
// latched frame against a reference built from the history of shifted bits.
// -----------------------------------------------------------------------------
module tb_seg_595_receiver;

    localparam int SEL_W   = 6;
    localparam int SEG_W   = 8;
    localparam int FRAME_W = SEL_W + SEG_W;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               ds;
    logic               shcp;
    logic               stcp;
    logic               oe;
    logic [FRAME_W-1:0] frame_data;
    logic [SEL_W-1:0]   sel;
    logic [SEG_W-1:0]   seg;
    logic [2:0]         digit_idx;
    logic               frame_valid;
    logic               frame_err;
    logic               sel_err;
    logic               disp_on;
    logic [3:0]         digit_val;
    logic               digit_ok;

    seg_595_receiver dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .ds          (ds),
        .shcp        (shcp),
        .stcp        (stcp),
        .oe          (oe),
        .frame_data  (frame_data),
        .sel         (sel),
        .seg         (seg),
        .digit_idx   (digit_idx),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel_err     (sel_err),
        .disp_on     (disp_on),
        .digit_val   (digit_val),
        .digit_ok    (digit_ok)
    );

    always #5 sys_clk = ~sys_clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference state: every bit shifted since reset, and shifts since the
    // last latch.
    bit hist[$];
    int shiftsSinceLatch = 0;

    logic [FRAME_W-1:0] expFrame;
    logic               expErr;
    logic               expSelErr;
    logic [2:0]         expIdx;
    logic [3:0]         expVal;
    logic               expOk;

    logic [6:0] glyphTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                  7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // The latched frame is simply the last FRAME_W bits shifted, oldest first,
    // padded with zeros if fewer have been shifted since reset.
    task automatic modelLatch();
        logic [FRAME_W-1:0] f;
        logic [SEL_W-1:0]   s;
        int start;
        f = '0;
        start = (hist.size() > FRAME_W) ? hist.size() - FRAME_W : 0;
        for (int i = start; i < hist.size(); i++) f = {f[FRAME_W-2:0], hist[i]};
        expFrame  = f;
        expErr    = (shiftsSinceLatch != FRAME_W);
        s         = f[FRAME_W-1:SEG_W];
        expSelErr = ($countones(s) != 1);
        expIdx    = 3'd0;
        if (!expSelErr)
            for (int i = 0; i < SEL_W; i++) if (s[i]) expIdx = 3'(i);
        expVal = 4'd0;
        expOk  = 1'b0;
`ifdef SEG595_RX_DECODE_EN
        for (int i = 0; i < 16; i++)
            if (f[6:0] == glyphTab[i]) begin
                expVal = 4'(i);
                expOk  = 1'b1;
            end
`endif
        shiftsSinceLatch = 0;
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, ".frame_data"}, 32'(frame_data), 32'(expFrame));
        checkOutput({tag, ".sel"},        32'(sel),        32'(expFrame[FRAME_W-1:SEG_W]));
        checkOutput({tag, ".seg"},        32'(seg),        32'(expFrame[SEG_W-1:0]));
        checkOutput({tag, ".digit_idx"},  32'(digit_idx),  32'(expIdx));
        checkOutput({tag, ".frame_err"},  32'(frame_err),  32'(expErr));
        checkOutput({tag, ".sel_err"},    32'(sel_err),    32'(expSelErr));
        checkOutput({tag, ".digit_val"},  32'(digit_val),  32'(expVal));
        checkOutput({tag, ".digit_ok"},   32'(digit_ok),   32'(expOk));
    endtask

    // One bus event: ds set up for 2 cycles, then shcp and/or stcp raised for
    // 3 cycles and held low for at least 5. Watches frame_valid for a bounded
    // window and checks its width and its 4-cycle latency.
    task automatic applyStimulus(input logic doShift, input logic doLatch, input logic b);
        int validCycles;
        int lat;
        @(negedge sys_clk);
        ds = b;
        repeat (2) @(negedge sys_clk);
        shcp = doShift;
        stcp = doLatch;
        if (doLatch) modelLatch();
        if (doShift) begin
            hist.push_back(b);
            if (hist.size() > 40) void'(hist.pop_front());
            if (shiftsSinceLatch < 31) shiftsSinceLatch++;
        end
        validCycles = 0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge sys_clk);
            if (c == 3) begin
                shcp = 1'b0;
                stcp = 1'b0;
            end
            if (frame_valid === 1'b1) begin
                validCycles++;
                if (lat == 0) lat = c;
            end
        end
        if (doLatch) begin
            checkOutput("valid_width", 32'(validCycles), 32'd1);
            checkOutput("valid_latency", 32'(lat), 32'd4);
            checkHeld("latch");
        end else begin
            checkOutput("no_valid_on_shift", 32'(validCycles), 32'd0);
        end
    endtask

    task automatic shiftBits(input logic [31:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) applyStimulus(1'b1, 1'b0, v[i]);
    endtask

    task automatic resetDut();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst.frame_data",  32'(frame_data),  32'd0);
        checkOutput("rst.frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("rst.frame_err",   32'(frame_err),   32'd0);
        checkOutput("rst.sel_err",     32'(sel_err),     32'd0);
        checkOutput("rst.digit_idx",   32'(digit_idx),   32'd0);
        checkOutput("rst.disp_on",     32'(disp_on),     32'd0);
        checkOutput("rst.digit_ok",    32'(digit_ok),    32'd0);
        sys_rst = 1'b0;
        hist.delete();
        shiftsSinceLatch = 0;
        expFrame = '0; expErr = 0; expSelErr = 0; expIdx = 0; expVal = 0; expOk = 0;
        repeat (4) @(negedge sys_clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [5:0]  rsel;
        logic [7:0]  rseg;
        int          nbits;

        sys_rst = 1'b1;
        ds = 0; shcp = 0; stcp = 0; oe = 1'b1;
        repeat (2) @(negedge sys_clk);
        resetDut();

        $display("[TB] frame for digit 4 on position 2");
        shiftBits(32'h0466, 14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t1.frame_data", 32'(frame_data), 32'h0466);
        checkOutput("t1.digit_idx",  32'(digit_idx),  32'd2);

        $display("[TB] short frame of 12 bits");
        shiftBits($urandom, 12);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2.frame_err", 32'(frame_err), 32'd1);
        shiftBits(32'h0806, 14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t2.cnt_cleared", 32'(frame_err), 32'd0);

        $display("[TB] shcp and stcp together");
        shiftBits(32'h105B, 14);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t3.prev_frame", 32'(frame_data), 32'h105B);
        shiftBits($urandom, 13);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3.frame_err", 32'(frame_err), 32'd0);

        $display("[TB] two bits set in sel");
        shiftBits({18'd0, 6'b000011, 8'h4F}, 14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4.sel_err",   32'(sel_err),   32'd1);
        checkOutput("t4.digit_idx", 32'(digit_idx), 32'd0);

        $display("[TB] reset in the middle of a frame");
        shiftBits(32'h7F, 7);
        resetDut();
        shiftBits({18'd0, 6'b100000, 8'h3F}, 14);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5.frame_data", 32'(frame_data), 32'h203F);
        checkOutput("t5.digit_idx",  32'(digit_idx),  32'd5);
        checkOutput("t5.frame_err",  32'(frame_err),  32'd0);

        $display("[TB] output enable tracking");
        @(negedge sys_clk);
        oe = 1'b0;
        @(negedge sys_clk); checkOutput("t6.on_c1", 32'(disp_on), 32'd0);
        @(negedge sys_clk); checkOutput("t6.on_c2", 32'(disp_on), 32'd0);
        @(negedge sys_clk); checkOutput("t6.on_c3", 32'(disp_on), 32'd1);
        oe = 1'b1;
        @(negedge sys_clk); checkOutput("t6.off_c1", 32'(disp_on), 32'd1);
        @(negedge sys_clk); checkOutput("t6.off_c2", 32'(disp_on), 32'd1);
        @(negedge sys_clk); checkOutput("t6.off_c3", 32'(disp_on), 32'd0);
        checkHeld("t6.held");

        $display("[TB] randomized frames");
        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(0, 9))
                0:       nbits = 0;
                1:       nbits = 12;
                2:       nbits = 17;
                3:       nbits = 13;
                default: nbits = 14;
            endcase
            rsel = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            rseg = ($urandom_range(0, 2) != 0)
                   ? {1'($urandom), glyphTab[$urandom_range(0, 15)]}
                   : 8'($urandom);
            v = ($urandom << 14) | {18'd0, rsel, rseg};
            shiftBits(v, nbits);
            if ($urandom_range(0, 4) == 0) applyStimulus(1'b1, 1'b1, 1'($urandom));
            else                           applyStimulus(1'b0, 1'b1, 1'b0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seg_595_receiver.md
Name: seg_595_receiver

Overview:
- Serial-in/parallel-out receiver for the 74HC595 display bus (ds, shcp, stcp, oe) driven by the display serializer.
- Samples the four bus lines in the sys_clk domain, rebuilds each latched frame, splits it into digit-select and segment fields, and flags malformed frames.
- Used in a loopback path: it mirrors the displayed digit back to a Nios PIO input and gives the bench a bus-level checker.

Parameters:
- SEL_W, 6, width of the digit-select field (one-hot, active-high).
- SEG_W, 8, width of the segment field, bit order {dp,g,f,e,d,c,b,a}, active-high.
- FRAME_W, SEL_W+SEG_W, total bits per frame; local, not overridable.

Ports:
- sys_clk  in  1  system clock, the only clock.
- sys_rst  in  1  synchronous reset, active-high.
- ds  in  1  serial data from the bus.
- shcp  in  1  shift clock from the bus; a rising edge shifts.
- stcp  in  1  storage clock from the bus; a rising edge latches.
- oe  in  1  output enable, active-low.
- frame_data  out  FRAME_W  last latched frame as {sel, seg}.
- sel  out  SEL_W  frame_data[FRAME_W-1:SEG_W].
- seg  out  SEG_W  frame_data[SEG_W-1:0].
- digit_idx  out  3  index of the set bit in sel; 0 if sel is not one-hot.
- frame_valid  out  1  one-cycle pulse when a new frame is latched.
- frame_err  out  1  registered with frame_valid: bit count since previous latch != FRAME_W.
- sel_err  out  1  registered with frame_valid: sel is not exactly one-hot.
- disp_on  out  1  registered ~oe.
- digit_val  out  4  hex value decoded from seg (feature).
- digit_ok  out  1  seg matches a hex glyph (feature).

Behaviour:
- Reset: every output and internal register goes to 0, including the synchronizer stages. disp_on resets to 0. A reset mid-frame discards all partial bits.
- Input sampling:
  - ds, shcp, stcp and oe each pass through a 2-flop synchronizer.
  - Edges are detected against a third registered copy.
  - shcp and stcp must each stay high and low for at least 2 sys_clk cycles. Faster toggling is not supported and not detected.
- Shift: on a detected shcp rise, shreg <= {shreg[FRAME_W-2:0], ds_sync}. The bit counter bit_cnt (5 bits) increments and saturates at 31.
- Latch: on a detected stcp rise:
  - frame_data <= shreg.
  - frame_valid pulses for 1 cycle.
  - frame_err <= (bit_cnt != FRAME_W).
  - sel_err is computed on the new sel.
  - digit_idx is updated.
  - bit_cnt clears to 0.
- Latency: frame_valid rises 4 sys_clk cycles after the stcp pin rise (2 synchronizer + 1 edge detect + 1 output register).
- Simultaneous shcp and stcp rise in the same cycle:
  - The latch takes the pre-shift shreg, matching the 595 one-behind behaviour.
  - The shift then occurs, and bit_cnt becomes 1 rather than 0.
- More than FRAME_W shifts before a latch: the oldest bits fall out of shreg, the frame latches normally, and frame_err=1.
- stcp with zero shifts: relatches the current shreg with frame_err=1.
- FSM, informational only and visible on a debug net:
  - IDLE → SHIFTING on the first shcp rise.
  - SHIFTING → LATCHED on an stcp rise.
  - LATCHED → SHIFTING on the next shcp rise.
  - Outputs do not depend on the state.
- Held values: frame_data, sel, seg, digit_idx, frame_err and sel_err hold until the next latch.
- disp_on: tracks oe with 3 cycles of latency and does not gate the frame logic.

Optional Feature:
- Macro: SEG595_RX_DECODE_EN.
- When defined:
  - A combinational glyph decoder on the latched seg (dp ignored) maps the standard 7-segment patterns for 0-F to digit_val.
  - digit_ok=1 on a match; digit_val=0 and digit_ok=0 otherwise.
  - digit_val and digit_ok are registered together with frame_data.
- When undefined: digit_val and digit_ok are tied to 0 and the decoder logic is absent. The ports remain in both builds.

Decomposition:
- Package seg595_pkg:
  - constants SEL_W_DEF=6 and SEG_W_DEF=8;
  - segment bit-position constants (SEG_A..SEG_DP);
  - the 16-entry hex glyph constant table, shared with the serializer;
  - the FSM state enum.
- One sub-module: seg595_edge_sync, a 2-flop synchronizer plus rise detector, instantiated twice (shcp, stcp).
- ds and oe use plain synchronizers inline.

Test Plan:
1. Shift 14 bits, sel=6'b000100 and seg=8'h66 ('4'), then pulse stcp → frame_valid 1 cycle; frame_data=14'h0466; digit_idx=2; frame_err=0; sel_err=0; with the macro defined, digit_val=4 and digit_ok=1.
2. Shift 12 bits, then stcp → frame_valid; frame_err=1; bit_cnt cleared.
3. Shift 14 bits; on the 15th shcp, rise stcp in the same sys_clk cycle → latch holds the pre-shift 14 bits; the next stcp after 13 further shifts reports frame_err=0.
4. Frame with sel=6'b000011 → sel_err=1, digit_idx=0.
5. Assert sys_rst after 7 shifts, release, shift 14 bits with sel=6'b100000 and seg=8'h3F, then stcp → frame_data=14'h203F, digit_idx=5, digit_val=0, digit_ok=1, frame_err=0.
6. Drive oe 0 → disp_on=1 after 3 cycles; drive oe 1 → disp_on=0 after 3 cycles; frame outputs unchanged.
